// File: rtl/result_bram_to_stream.sv
// ============================================================================
//  Module   : result_bram_to_stream
//  Purpose  : Reads 16-bit results packed 16 per 256-bit BRAM line and streams
//             them out with valid/ready. Optional statistics counters are
//             enabled by defining RESULT_BRAM_TO_STREAM_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_bram_to_stream (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_clear,
  input  logic [12:0]   i_wr_ptr,
  output logic [12:0]   o_rd_ptr,
  output logic          o_bram_rd_en,
  output logic [8:0]    o_bram_rd_addr,
  input  logic [255:0]  i_bram_rd_data,
  output logic [15:0]   o_result_data,
  output logic          o_result_valid,
  input  logic          i_result_ready,
  output logic [13:0]   o_used_entries,
  output logic          o_empty
`ifdef RESULT_BRAM_TO_STREAM_STATS_EN
  ,
  output logic [31:0]   o_pop_count,
  output logic [15:0]   o_refetch_count
`endif
);

  localparam logic [4:0] FULL_LINE = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [12:0]   rd_ptr_q, rd_ptr_d;
  logic [255:0]  line_buf_q, line_buf_d;
  logic [4:0]    lane_lim_q, lane_lim_d;

  logic [12:0]   used;
  logic [12:0]   rd_ptr_inc;
  logic          pop;
  logic          limit_refetch;

  assign used           = i_wr_ptr - rd_ptr_q;
  assign o_used_entries = {1'b0, used};
  assign o_empty        = (used == 13'd0);
  assign o_rd_ptr       = rd_ptr_q;
  assign o_bram_rd_en   = (state_q == ST_FETCH);
  assign o_bram_rd_addr = rd_ptr_q[12:4];
  assign o_result_valid = (state_q == ST_OUT);
  assign o_result_data  = line_buf_q[{rd_ptr_q[3:0], 4'b0000} +: 16];
  assign pop            = o_result_valid && i_result_ready;
  assign rd_ptr_inc     = rd_ptr_q + 13'd1;

  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    line_buf_d    = line_buf_q;
    lane_lim_d    = lane_lim_q;
    limit_refetch = 1'b0;
    if (i_clear) begin
      // Clear overrides everything, including a pop in this same cycle.
      rd_ptr_d = i_wr_ptr;
      state_d  = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!o_empty) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          // A line shared with the producer is only trusted up to its write lane.
          lane_lim_d = (i_wr_ptr[12:4] == rd_ptr_q[12:4]) ? {1'b0, i_wr_ptr[3:0]} : FULL_LINE;
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          line_buf_d = i_bram_rd_data;
          state_d    = ST_OUT;
        end
        ST_OUT: begin
          if (pop) begin
            rd_ptr_d = rd_ptr_inc;
            if (rd_ptr_inc == i_wr_ptr) begin
              state_d = ST_IDLE;
            end else if (rd_ptr_inc[3:0] == 4'd0) begin
              state_d = ST_FETCH;
            end else if ({1'b0, rd_ptr_inc[3:0]} >= lane_lim_q) begin
              state_d       = ST_FETCH;
              limit_refetch = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= 13'd0;
      line_buf_q <= 256'd0;
      lane_lim_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      line_buf_q <= line_buf_d;
      lane_lim_q <= lane_lim_d;
    end
  end

`ifdef RESULT_BRAM_TO_STREAM_STATS_EN
  logic [31:0] pop_count_q, pop_count_d;
  logic [15:0] refetch_count_q, refetch_count_d;

  always_comb begin
    pop_count_d     = pop_count_q;
    refetch_count_d = refetch_count_q;
    if (i_clear) begin
      pop_count_d = 32'd0;
    end else if (pop && (pop_count_q != 32'hFFFF_FFFF)) begin
      pop_count_d = pop_count_q + 32'd1;
    end
    if (limit_refetch && (refetch_count_q != 16'hFFFF)) begin
      refetch_count_d = refetch_count_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pop_count_q     <= 32'd0;
      refetch_count_q <= 16'd0;
    end else begin
      pop_count_q     <= pop_count_d;
      refetch_count_q <= refetch_count_d;
    end
  end

  assign o_pop_count     = pop_count_q;
  assign o_refetch_count = refetch_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_result_bram_to_stream.sv
// ============================================================================
//  Module   : tb_result_bram_to_stream
//  Purpose  : Scoreboard bench for result_bram_to_stream with a 1-cycle BRAM.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_bram_to_stream;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_clear;
  logic [12:0]   i_wr_ptr;
  logic [12:0]   o_rd_ptr;
  logic          o_bram_rd_en;
  logic [8:0]    o_bram_rd_addr;
  logic [255:0]  i_bram_rd_data;
  logic [15:0]   o_result_data;
  logic          o_result_valid;
  logic          i_result_ready;
  logic [13:0]   o_used_entries;
  logic          o_empty;
`ifdef RESULT_BRAM_TO_STREAM_STATS_EN
  logic [31:0]   o_pop_count;
  logic [15:0]   o_refetch_count;
`endif

  always #5 i_clk = ~i_clk;

  result_bram_to_stream dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_clear        (i_clear),
    .i_wr_ptr       (i_wr_ptr),
    .o_rd_ptr       (o_rd_ptr),
    .o_bram_rd_en   (o_bram_rd_en),
    .o_bram_rd_addr (o_bram_rd_addr),
    .i_bram_rd_data (i_bram_rd_data),
    .o_result_data  (o_result_data),
    .o_result_valid (o_result_valid),
    .i_result_ready (i_result_ready),
    .o_used_entries (o_used_entries),
    .o_empty        (o_empty)
`ifdef RESULT_BRAM_TO_STREAM_STATS_EN
    ,
    .o_pop_count    (o_pop_count),
    .o_refetch_count(o_refetch_count)
`endif
  );

  logic [255:0] mem [512];
  logic [15:0]  sb [$];
  int           pop_cyc [$];
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_bram_rd_en) i_bram_rd_data <= mem[o_bram_rd_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic put_entry(input logic [12:0] p, input logic [15:0] v);
    mem[p[12:4]][{p[3:0], 4'b0000} +: 16] = v;
    sb.push_back(v);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || !o_empty || o_result_valid) && n < 300) begin
      tick();
      n++;
    end
    check_val({tag, "_drain"}, {31'd0, n < 300}, 32'd1);
  endtask

  // Output monitor: scoreboard compare on every handshake, hold check on stalls.
  initial begin
    logic        hold_chk;
    logic [15:0] held;
    logic [15:0] exp;
    hold_chk = 1'b0;
    held     = 16'd0;
    forever begin
      @(negedge i_clk);
      if (i_reset_n) begin
        if (hold_chk) begin
          check_val("hold_valid", {31'd0, o_result_valid}, 32'd1);
          check_val("hold_data", {16'd0, o_result_data}, {16'd0, held});
        end
        hold_chk = o_result_valid && !i_result_ready && !i_clear;
        held     = o_result_data;
        if (o_result_valid && i_result_ready && !i_clear) begin
          if (sb.size() == 0) begin
            check_val("extra_beat", {31'd0, o_result_valid}, 32'd0);
          end else begin
            exp = sb.pop_front();
            check_val("beat", {16'd0, o_result_data}, {16'd0, exp});
            pop_cyc.push_back(cyc);
          end
        end
      end else begin
        hold_chk = 1'b0;
      end
    end
  end

  initial begin
    int seq;
    int ok;
    for (int i = 0; i < 512; i++) mem[i] = 256'd0;
    i_bram_rd_data = 256'd0;
    i_reset_n      = 1'b0;
    i_clear        = 1'b0;
    i_wr_ptr       = 13'd0;
    i_result_ready = 1'b1;
    #12;
    check_val("rst_rd_ptr", {19'd0, o_rd_ptr}, 32'd0);
    check_val("rst_valid", {31'd0, o_result_valid}, 32'd0);
    check_val("rst_rd_en", {31'd0, o_bram_rd_en}, 32'd0);
    check_val("rst_addr", {23'd0, o_bram_rd_addr}, 32'd0);
    check_val("rst_data", {16'd0, o_result_data}, 32'd0);
    check_val("rst_empty", {31'd0, o_empty}, 32'd1);
    tick();
    i_reset_n = 1'b1;
    tick();

    // Single entry with exact latency
    put_entry(13'd0, 16'h253e);
    i_wr_ptr = 13'd1;
    tick();
    check_val("t1_rd_en", {31'd0, o_bram_rd_en}, 32'd1);
    check_val("t1_addr", {23'd0, o_bram_rd_addr}, 32'd0);
    tick();
    check_val("t1_wait_valid", {31'd0, o_result_valid}, 32'd0);
    tick();
    check_val("t1_out_valid", {31'd0, o_result_valid}, 32'd1);
    check_val("t1_out_data", {16'd0, o_result_data}, 32'h253e);
    wait_drain("t1");
    check_val("t1_rd_ptr", {19'd0, o_rd_ptr}, 32'd1);
    check_val("t1_empty", {31'd0, o_empty}, 32'd1);
    tick();
    check_val("t1_idle_rd_en", {31'd0, o_bram_rd_en}, 32'd0);

    // Partial line extended: line 0 must be re-read
    put_entry(13'd1, 16'h22f7);
    put_entry(13'd2, 16'h25b7);
    put_entry(13'd3, 16'ha390);
    put_entry(13'd4, 16'ha40a);
    i_wr_ptr = 13'd5;
    wait_drain("t2");
    check_val("t2_rd_ptr", {19'd0, o_rd_ptr}, 32'd5);

    // Line crossing with ready held high
    i_wr_ptr = 13'd0;
    i_clear  = 1'b1;
    tick();
    i_clear = 1'b0;
    check_val("t3_clr_rd_ptr", {19'd0, o_rd_ptr}, 32'd0);
    pop_cyc.delete();
    for (int i = 0; i < 20; i++) put_entry(13'(i), 16'(i));
    i_wr_ptr = 13'd20;
    wait_drain("t3");
    check_val("t3_beats", pop_cyc.size(), 32'd20);
    if (pop_cyc.size() >= 20) begin
      seq = 0;
      for (int i = 1; i < 16; i++) if (pop_cyc[i] - pop_cyc[i-1] == 1) seq++;
      check_val("t3_line0_back2back", seq, 32'd15);
      check_val("t3_line_gap", pop_cyc[16] - pop_cyc[15], 32'd3);
      seq = 0;
      for (int i = 17; i < 20; i++) if (pop_cyc[i] - pop_cyc[i-1] == 1) seq++;
      check_val("t3_line1_back2back", seq, 32'd3);
    end
    check_val("t3_rd_ptr", {19'd0, o_rd_ptr}, 32'd20);

    // Backpressure: ready toggles every cycle
    for (int i = 20; i < 30; i++) put_entry(13'(i), 16'(16'h1000 + i));
    i_wr_ptr = 13'd30;
    for (int i = 0; i < 40; i++) begin
      i_result_ready = ~i_result_ready;
      tick();
    end
    i_result_ready = 1'b1;
    wait_drain("t4");
    check_val("t4_rd_ptr", {19'd0, o_rd_ptr}, 32'd30);

    // Pointer wrap across line 511 -> line 0
    i_wr_ptr = 13'd8190;
    i_clear  = 1'b1;
    tick();
    i_clear = 1'b0;
    check_val("t5_clr_rd_ptr", {19'd0, o_rd_ptr}, 32'd8190);
    check_val("t5_used0", {18'd0, o_used_entries}, 32'd0);
    put_entry(13'd8190, 16'hbe0e);
    put_entry(13'd8191, 16'hbe0f);
    put_entry(13'd0, 16'ha000);
    put_entry(13'd1, 16'ha001);
    i_wr_ptr = 13'd2;
    #1;
    check_val("t5_used4", {18'd0, o_used_entries}, 32'd4);
    wait_drain("t5");
    check_val("t5_used_end", {18'd0, o_used_entries}, 32'd0);
    check_val("t5_rd_ptr", {19'd0, o_rd_ptr}, 32'd2);
`ifdef RESULT_BRAM_TO_STREAM_STATS_EN
    check_val("t5_pop_count", o_pop_count, 32'd4);
`endif

    // Clear in the middle of a line with 6 unread entries
    i_result_ready = 1'b0;
    for (int i = 2; i < 10; i++) put_entry(13'(i), 16'(16'h6000 + i));
    i_wr_ptr = 13'd10;
    ok = 0;
    for (int i = 0; i < 20 && !o_result_valid; i++) tick();
    check_val("t6_valid", {31'd0, o_result_valid}, 32'd1);
    i_result_ready = 1'b1;
    tick();
    tick();
    i_result_ready = 1'b0;
    check_val("t6_unread", sb.size(), 32'd6);
    check_val("t6_used6", {18'd0, o_used_entries}, 32'd6);
    sb.delete();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    check_val("t6_clr_valid", {31'd0, o_result_valid}, 32'd0);
    check_val("t6_clr_rd_ptr", {19'd0, o_rd_ptr}, 32'd10);
    check_val("t6_clr_used", {18'd0, o_used_entries}, 32'd0);
    check_val("t6_clr_empty", {31'd0, o_empty}, 32'd1);
`ifdef RESULT_BRAM_TO_STREAM_STATS_EN
    check_val("t6_pop_count", o_pop_count, 32'd0);
`endif
    i_result_ready = 1'b1;
    repeat (10) tick();
    check_val("t6_quiet_valid", {31'd0, o_result_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
